control_unit_multicycle: RTL and testbench

//  Multi-cycle successor of the single-cycle MIPS32-modified control unit. Sequences each instruction

---
 rtl/control_unit_multicycle_pkg.sv | 63 ++++++
 rtl/control_unit_multicycle_mem_watchdog.sv | 34 +++
 rtl/control_unit_multicycle.sv | 208 ++++++++++++++++++++
 tb/tb_control_unit_multicycle.sv | 257 +++++++++++++++++++++++++
 4 files changed

// File: rtl/control_unit_multicycle_pkg.sv
// Shared opcodes, ALU operation codes, FSM state encodings and the control-strobe bundle
// for the multi-cycle MIPS32-modified control unit.
package control_unit_multicycle_pkg;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_BNE   = 6'b000101;
  localparam logic [5:0] OP_ORI   = 6'b001101;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_JAL   = 6'b000011;
  localparam logic [5:0] OP_LUI   = 6'b001111;

  localparam logic [1:0] ALU_ADD   = 2'b00;
  localparam logic [1:0] ALU_SUB   = 2'b01;
  localparam logic [1:0] ALU_FUNCT = 2'b10;
  localparam logic [1:0] ALU_OR    = 2'b11;

  typedef enum logic [3:0] {
    S_RST    = 4'd0,
    S_FETCH  = 4'd1,
    S_DECODE = 4'd2,
    S_ADDR   = 4'd3,
    S_MEM_RD = 4'd4,
    S_MEM_WR = 4'd5,
    S_WB_MEM = 4'd6,
    S_EXEC_R = 4'd7,
    S_WB_R   = 4'd8,
    S_EXEC_I = 4'd9,
    S_WB_I   = 4'd10,
    S_BRANCH = 4'd11,
    S_FAULT  = 4'd12
  } state_t;

  typedef struct packed {
    logic       mem_req;
    logic       memRead;
    logic       memWrite;
    logic       iOrD;
    logic       pcWrite;
    logic       regDst;
    logic       aluSrc;
    logic       memToReg;
    logic       regWrite;
    logic       regWrite2;
    logic       branch;
    logic       branchN;
    logic       lui;
    logic       jump;
    logic       jal;
    logic [1:0] aluop;
    logic       fault;
  } ctrl_t;

  function automatic logic is_known_op(input logic [5:0] op);
    case (op)
      OP_RTYPE, OP_LW, OP_SW, OP_BEQ, OP_BNE, OP_ORI, OP_J, OP_JAL, OP_LUI: return 1'b1;
      default: return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/control_unit_multicycle_mem_watchdog.sv
// Memory-wait watchdog: counts consecutive stalled request cycles, pulses expire on the TIMEOUT-th one.
// Latency: expire is combinational in the stalling cycle; backpressure: none, observes the handshake only.
module control_unit_multicycle_mem_watchdog #(
  parameter int TIMEOUT = 15,
  parameter int TO_W    = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic mem_req,
  input  logic mem_ready,
  output logic expire
);

  localparam logic [TO_W-1:0] LAST = (TIMEOUT > 0) ? TO_W'(TIMEOUT - 1) : '0;

  logic [TO_W-1:0] cnt;
  logic            stall;

  assign stall  = mem_req && !mem_ready;
  // Fires during the TIMEOUT-th stall so the FSM leaves on the edge the count would reach TIMEOUT.
  assign expire = (TIMEOUT != 0) && stall && (cnt == LAST);

  // mem_req drops whenever the FSM leaves a memory state, so !stall also covers the state exit.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (stall && !expire) begin
      cnt <= cnt + 1'b1;
    end else begin
      cnt <= '0;
    end
  end

endmodule

// File: rtl/control_unit_multicycle.sv
// Multi-cycle MIPS32-modified control FSM with memory handshake, watchdog fault and retire counter.
// Latency: registered Moore strobes, 2-5+ cycles per instruction; backpressure: stalls in memory states until mem_ready.
module control_unit_multicycle
  import control_unit_multicycle_pkg::*;
#(
  parameter int OP_W    = 6,
  parameter int TIMEOUT = 15,
  parameter int TO_W    = 4,
  parameter int CNT_W   = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [OP_W-1:0]  op,
  input  logic             mem_ready,
  output logic             mem_req,
  output logic             memRead,
  output logic             memWrite,
  output logic             iOrD,
  output logic             irWrite,
  output logic             pcWrite,
  output logic             regDst,
  output logic             aluSrc,
  output logic             memToReg,
  output logic             regWrite,
  output logic             regWrite2,
  output logic             branch,
  output logic             branchN,
  output logic             lui,
  output logic             jump,
  output logic             jal,
  output logic [1:0]       aluop,
  output logic             fault,
  output logic [3:0]       state,
  output logic [CNT_W-1:0] retired
);

  state_t          state_q, state_d;
  logic [OP_W-1:0] op_q, op_d;
  ctrl_t           ctrl_q;
  logic            ir_write;
  logic            expire;
  logic            retire;

  control_unit_multicycle_mem_watchdog #(
    .TIMEOUT (TIMEOUT),
    .TO_W    (TO_W)
  ) u_mem_watchdog (
    .clk       (clk),
    .rst_n     (rst_n),
    .mem_req   (ctrl_q.mem_req),
    .mem_ready (mem_ready),
    .expire    (expire)
  );

  assign ir_write = (state_q == S_FETCH) && mem_ready;
  assign op_d     = ir_write ? op : op_q;

  function automatic ctrl_t decode(input state_t s, input logic [OP_W-1:0] o);
    ctrl_t c;
    c = '0;
    case (s)
      S_FETCH: begin
        c.mem_req = 1'b1;
        c.memRead = 1'b1;
        c.aluop   = ALU_ADD;
      end
      S_DECODE: begin
        case (o)
          OP_J: begin
            c.jump    = 1'b1;
            c.pcWrite = 1'b1;
          end
          OP_JAL: begin
            c.jump     = 1'b1;
            c.jal      = 1'b1;
            c.regWrite = 1'b1;
            c.pcWrite  = 1'b1;
          end
          OP_LUI: begin
            c.lui      = 1'b1;
            c.regWrite = 1'b1;
          end
          default: c = '0;
        endcase
      end
      S_ADDR: begin
        c.aluSrc = 1'b1;
        c.aluop  = ALU_ADD;
      end
      S_MEM_RD: begin
        c.mem_req = 1'b1;
        c.memRead = 1'b1;
        c.iOrD    = 1'b1;
      end
      S_MEM_WR: begin
        c.mem_req  = 1'b1;
        c.memWrite = 1'b1;
        c.iOrD     = 1'b1;
      end
      S_WB_MEM: begin
        c.memToReg = 1'b1;
        c.regWrite = 1'b1;
      end
      S_EXEC_R: begin
        c.regDst = 1'b1;
        c.aluop  = ALU_FUNCT;
      end
      S_WB_R: begin
        c.regDst    = 1'b1;
        c.regWrite  = 1'b1;
        c.regWrite2 = 1'b1;
        c.aluop     = ALU_FUNCT;
      end
      S_EXEC_I: begin
        c.aluSrc = 1'b1;
        c.aluop  = ALU_OR;
      end
      S_WB_I: begin
        c.aluSrc   = 1'b1;
        c.regWrite = 1'b1;
        c.aluop    = ALU_OR;
      end
      S_BRANCH: begin
        c.aluop   = ALU_SUB;
        c.branch  = (o == OP_BEQ);
        c.branchN = (o == OP_BNE);
      end
      S_FAULT: c.fault = 1'b1;
      default: c = '0;
    endcase
    return c;
  endfunction

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_RST:    state_d = S_FETCH;
      S_FETCH: begin
        if (expire)         state_d = S_FAULT;
        else if (mem_ready) state_d = S_DECODE;
      end
      S_DECODE: begin
        case (op_q)
          OP_LW, OP_SW:   state_d = S_ADDR;
          OP_BEQ, OP_BNE: state_d = S_BRANCH;
          OP_RTYPE:       state_d = S_EXEC_R;
          OP_ORI:         state_d = S_EXEC_I;
          default:        state_d = S_FETCH;
        endcase
      end
      S_ADDR:   state_d = (op_q == OP_LW) ? S_MEM_RD : S_MEM_WR;
      S_MEM_RD: begin
        if (expire)         state_d = S_FAULT;
        else if (mem_ready) state_d = S_WB_MEM;
      end
      S_MEM_WR: begin
        if (expire)         state_d = S_FAULT;
        else if (mem_ready) state_d = S_FETCH;
      end
      S_EXEC_R: state_d = S_WB_R;
      S_EXEC_I: state_d = S_WB_I;
      S_WB_MEM, S_WB_R, S_WB_I, S_BRANCH: state_d = S_FETCH;
      S_FAULT:  state_d = S_FAULT;
      default:  state_d = S_RST;
    endcase
  end

  // An instruction retires on the cycle that hands control back to FETCH; unknown opcodes do not count.
  assign retire = (state_d == S_FETCH)
               && !(state_q inside {S_RST, S_FETCH, S_FAULT})
               && !((state_q == S_DECODE) && !is_known_op(op_q));

  // Strobes are registered from the next state so they line up with state_q in the same cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_RST;
      op_q    <= '0;
      ctrl_q  <= '0;
      retired <= '0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      ctrl_q  <= decode(state_d, op_d);
      if (retire) retired <= retired + CNT_W'(1);
    end
  end

  assign mem_req   = ctrl_q.mem_req;
  assign memRead   = ctrl_q.memRead;
  assign memWrite  = ctrl_q.memWrite;
  assign iOrD      = ctrl_q.iOrD;
  assign irWrite   = ir_write;
  assign pcWrite   = ctrl_q.pcWrite | ir_write;
  assign regDst    = ctrl_q.regDst;
  assign aluSrc    = ctrl_q.aluSrc;
  assign memToReg  = ctrl_q.memToReg;
  assign regWrite  = ctrl_q.regWrite;
  assign regWrite2 = ctrl_q.regWrite2;
  assign branch    = ctrl_q.branch;
  assign branchN   = ctrl_q.branchN;
  assign lui       = ctrl_q.lui;
  assign jump      = ctrl_q.jump;
  assign jal       = ctrl_q.jal;
  assign aluop     = ctrl_q.aluop;
  assign fault     = ctrl_q.fault;
  assign state     = state_q;

endmodule

// File: tb/tb_control_unit_multicycle.sv
// Bench for control_unit_multicycle: an instruction-level model expands each opcode and its memory
// latencies into expected per-cycle states/strobes; a negedge process compares them against the DUT.
module tb_control_unit_multicycle;
  import control_unit_multicycle_pkg::*;

  localparam logic [5:0] RT  = 6'b000000;
  localparam logic [5:0] LW  = 6'b100011;
  localparam logic [5:0] SW  = 6'b101011;
  localparam logic [5:0] BEQ = 6'b000100;
  localparam logic [5:0] BNE = 6'b000101;
  localparam logic [5:0] ORI = 6'b001101;
  localparam logic [5:0] J   = 6'b000010;
  localparam logic [5:0] JAL = 6'b000011;
  localparam logic [5:0] LUI = 6'b001111;

  typedef struct packed {
    logic mem_req, memRead, memWrite, iOrD, irWrite, pcWrite, regDst, aluSrc;
    logic memToReg, regWrite, regWrite2, branch, branchN, lui, jump, jal;
    logic [1:0] aluop;
    logic fault;
  } o_t;

  typedef struct packed {
    logic [3:0]  st;
    o_t          o;
    logic [31:0] ret;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [5:0]  op;
  logic        mem_ready;
  logic        mem_req, memRead, memWrite, iOrD, irWrite, pcWrite, regDst, aluSrc;
  logic        memToReg, regWrite, regWrite2, branch, branchN, lui, jump, jal, fault;
  logic [1:0]  aluop;
  logic [3:0]  state;
  logic [31:0] retired;

  o_t   act;
  exp_t exp_q[$];
  exp_t cur;
  int   total = 0;
  int   bad = 0;
  int   model_ret = 0;
  logic mon_en = 1'b0;
  int   mw_cnt, jump_cnt, rw2_cnt;
  logic rw_seen;

  control_unit_multicycle dut (
    .clk(clk), .rst_n(rst_n), .op(op), .mem_ready(mem_ready),
    .mem_req(mem_req), .memRead(memRead), .memWrite(memWrite), .iOrD(iOrD),
    .irWrite(irWrite), .pcWrite(pcWrite), .regDst(regDst), .aluSrc(aluSrc),
    .memToReg(memToReg), .regWrite(regWrite), .regWrite2(regWrite2),
    .branch(branch), .branchN(branchN), .lui(lui), .jump(jump), .jal(jal),
    .aluop(aluop), .fault(fault), .state(state), .retired(retired)
  );

  always #5 clk = ~clk;

  assign act = {mem_req, memRead, memWrite, iOrD, irWrite, pcWrite, regDst, aluSrc,
                memToReg, regWrite, regWrite2, branch, branchN, lui, jump, jal, aluop, fault};

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s at t=%0t: got %0h want %0h", name, $time, got, want);
    end
  endtask

  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      cur = exp_q.pop_front();
      chk("state", 64'(state), 64'(cur.st));
      chk("outs", 64'(act), 64'(cur.o));
      chk("retired", 64'(retired), 64'(cur.ret));
    end
  end

  always @(negedge clk) begin
    if (!mon_en) begin
      mw_cnt = 0; jump_cnt = 0; rw2_cnt = 0; rw_seen = 1'b0;
    end else begin
      if (memWrite)  mw_cnt++;
      if (jump)      jump_cnt++;
      if (regWrite2) rw2_cnt++;
      if (regWrite)  rw_seen = 1'b1;
    end
  end

  function automatic logic known(input logic [5:0] o);
    return (o == RT) || (o == LW) || (o == SW) || (o == BEQ) || (o == BNE) ||
           (o == ORI) || (o == J) || (o == JAL) || (o == LUI);
  endfunction

  // One clock cycle: drive inputs, record what this cycle must look like, advance.
  task automatic cyc(input logic rdy, input logic [5:0] opv, input logic [3:0] st, input o_t o);
    exp_t e;
    mem_ready = rdy;
    op        = opv;
    e.st  = st;
    e.o   = o;
    e.ret = 32'(model_ret);
    exp_q.push_back(e);
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    model_ret = 0;
    cyc(1'b1, 6'h00, S_RST, '0);
  endtask

  // Expands one instruction into its cycles; fwait/mwait = stalled cycles before mem_ready.
  task automatic run_instr(input logic [5:0] opc, input int fwait, input int mwait);
    o_t o;
    logic [5:0] junk;
    junk = ~opc;
    for (int k = 0; k <= fwait; k++) begin
      o = '0; o.mem_req = 1'b1; o.memRead = 1'b1;
      if (k == fwait) begin o.irWrite = 1'b1; o.pcWrite = 1'b1; end
      cyc(k == fwait, opc, S_FETCH, o);
    end
    o = '0;
    if (opc == J)   begin o.jump = 1'b1; o.pcWrite = 1'b1; end
    if (opc == JAL) begin o.jump = 1'b1; o.jal = 1'b1; o.regWrite = 1'b1; o.pcWrite = 1'b1; end
    if (opc == LUI) begin o.lui = 1'b1; o.regWrite = 1'b1; end
    cyc(1'b1, junk, S_DECODE, o);
    if (opc == LW || opc == SW) begin
      o = '0; o.aluSrc = 1'b1;
      cyc(1'b1, junk, S_ADDR, o);
      for (int k = 0; k <= mwait; k++) begin
        o = '0; o.mem_req = 1'b1; o.iOrD = 1'b1;
        if (opc == LW) o.memRead = 1'b1; else o.memWrite = 1'b1;
        cyc(k == mwait, junk, (opc == LW) ? S_MEM_RD : S_MEM_WR, o);
      end
      if (opc == LW) begin
        o = '0; o.memToReg = 1'b1; o.regWrite = 1'b1;
        cyc(1'b1, junk, S_WB_MEM, o);
      end
    end else if (opc == BEQ || opc == BNE) begin
      o = '0; o.aluop = 2'b01; o.branch = (opc == BEQ); o.branchN = (opc == BNE);
      cyc(1'b1, junk, S_BRANCH, o);
    end else if (opc == RT) begin
      o = '0; o.regDst = 1'b1; o.aluop = 2'b10;
      cyc(1'b1, junk, S_EXEC_R, o);
      o.regWrite = 1'b1; o.regWrite2 = 1'b1;
      cyc(1'b1, junk, S_WB_R, o);
    end else if (opc == ORI) begin
      o = '0; o.aluSrc = 1'b1; o.aluop = 2'b11;
      cyc(1'b1, junk, S_EXEC_I, o);
      o.regWrite = 1'b1;
      cyc(1'b1, junk, S_WB_I, o);
    end
    if (known(opc)) model_ret++;
  endtask

  initial begin
    o_t o;
    rst_n = 1'b0; mem_ready = 1'b0; op = 6'h00;
    #2;
    chk("reset_state", 64'(state), 64'd0);
    chk("reset_outs", 64'(act), 64'd0);
    chk("reset_retired", 64'(retired), 64'd0);
    @(posedge clk); #1;
    do_reset();

    // 1: lw with memory always ready
    run_instr(LW, 0, 0);
    chk("t1_retired", 64'(retired), 64'd1);

    // 2: sw with 3-cycle write latency, then lw just under the watchdog limit
    do_reset();
    mon_en = 1'b1;
    run_instr(SW, 0, 3);
    chk("t2_memwrite_cycles", 64'(mw_cnt), 64'd4);
    chk("t2_regwrite_seen", 64'(rw_seen), 64'd0);
    chk("t2_retired", 64'(retired), 64'd1);
    mon_en = 1'b0;
    run_instr(LW, 14, 14);
    chk("t2_no_fault", 64'(fault), 64'd0);
    chk("t2_retired2", 64'(retired), 64'd2);

    // 3: branch/jump/immediate/R-type mix
    do_reset();
    mon_en = 1'b1;
    run_instr(BEQ, 1, 0);
    run_instr(BNE, 0, 0);
    run_instr(J,   2, 0);
    run_instr(JAL, 0, 0);
    run_instr(LUI, 0, 0);
    run_instr(ORI, 1, 0);
    run_instr(RT,  0, 0);
    chk("t3_retired", 64'(retired), 64'd7);
    chk("t3_jump_cycles", 64'(jump_cnt), 64'd2);
    chk("t3_rw2_cycles", 64'(rw2_cnt), 64'd1);
    mon_en = 1'b0;

    // 4: lui retires, unknown opcode does not
    run_instr(LUI, 0, 0);
    run_instr(6'b111111, 0, 0);
    chk("t4_retired", 64'(retired), 64'd8);

    // 5: fetch never acknowledged -> fault after 15 stalled cycles, sticky
    do_reset();
    for (int k = 0; k < 15; k++) begin
      o = '0; o.mem_req = 1'b1; o.memRead = 1'b1;
      cyc(1'b0, LW, S_FETCH, o);
    end
    for (int k = 0; k < 6; k++) begin
      o = '0; o.fault = 1'b1;
      cyc(k[0], LW, S_FAULT, o);
    end
    chk("t5_fault", 64'(fault), 64'd1);
    chk("t5_state", 64'(state), 64'(S_FAULT));
    do_reset();
    chk("t5_fault_cleared", 64'(fault), 64'd0);

    // 6: asynchronous reset in the middle of a load
    run_instr(LUI, 0, 0);
    o = '0; o.mem_req = 1'b1; o.memRead = 1'b1; o.irWrite = 1'b1; o.pcWrite = 1'b1;
    cyc(1'b1, LW, S_FETCH, o);
    cyc(1'b1, 6'h00, S_DECODE, '0);
    o = '0; o.aluSrc = 1'b1;
    cyc(1'b1, 6'h00, S_ADDR, o);
    o = '0; o.mem_req = 1'b1; o.memRead = 1'b1; o.iOrD = 1'b1;
    cyc(1'b0, 6'h00, S_MEM_RD, o);
    cyc(1'b0, 6'h00, S_MEM_RD, o);
    chk("t6_pre_retired", 64'(retired), 64'd1);
    rst_n = 1'b0;
    #1;
    chk("t6_async_outs", 64'(act), 64'd0);
    chk("t6_async_state", 64'(state), 64'd0);
    chk("t6_async_retired", 64'(retired), 64'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    model_ret = 0;
    cyc(1'b1, 6'h00, S_RST, '0);
    run_instr(ORI, 0, 0);
    chk("t6_retired", 64'(retired), 64'd1);

    chk("queue_drained", 64'(exp_q.size()), 64'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

endmodule
